// File: rtl/sprite_position_ctrl.sv
// Joystick-driven sprite position controller.
// Synchronizes four direction buttons, steps a clamped joystick position at a fixed
// rate, latches it into the player position once per frame on the vsync rising edge,
// and compares the player position against the beam to form hstart/vstart strobes.
module sprite_position_ctrl #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned SPRITE_W  = 16,
    parameter int unsigned SPRITE_H  = 16,
    parameter int unsigned TICK_DIV  = 250000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_vsync,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    output logic [9:0] o_joy_x,
    output logic [9:0] o_joy_y,
    output logic [9:0] o_player_x,
    output logic [9:0] o_player_y,
    output logic       o_hstart,
    output logic       o_vstart,
    output logic       o_step_tick
);

    localparam logic [9:0]  X_MAX     = 10'(H_DISPLAY - SPRITE_W);
    localparam logic [9:0]  Y_MAX     = 10'(V_DISPLAY - SPRITE_H);
    localparam logic [9:0]  X_RESET   = 10'(H_DISPLAY / 2);
    localparam logic [9:0]  Y_RESET   = 10'(V_DISPLAY / 2);
    localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

    // Button bit order: {left, right, up, down}
    logic [3:0]  r_btn_meta;
    logic [3:0]  r_btn_sync;
    logic [23:0] r_presc;
    logic        r_step_tick;
    logic [9:0]  r_joy_x;
    logic [9:0]  r_joy_y;
    logic [9:0]  r_player_x;
    logic [9:0]  r_player_y;
    logic        r_vsync_prev;

    logic        w_left;
    logic        w_right;
    logic        w_up;
    logic        w_down;
    logic        w_vsync_rise;
    logic [9:0]  w_joy_x_next;
    logic [9:0]  w_joy_y_next;

    assign w_left       = r_btn_sync[3];
    assign w_right      = r_btn_sync[2];
    assign w_up         = r_btn_sync[1];
    assign w_down       = r_btn_sync[0];
    assign w_vsync_rise = i_vsync & ~r_vsync_prev;

    // Two-flop synchronizer for the raw asynchronous buttons
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_btn_meta <= 4'b0000;
            r_btn_sync <= 4'b0000;
        end else begin
            r_btn_meta <= {i_left, i_right, i_up, i_down};
            r_btn_sync <= r_btn_meta;
        end
    end

    // Step prescaler: wraps every TICK_DIV cycles, tick is registered one cycle after wrap
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_presc     <= 24'd0;
            r_step_tick <= 1'b0;
        end else if (r_presc == TICK_LAST) begin
            r_presc     <= 24'd0;
            r_step_tick <= 1'b1;
        end else begin
            r_presc     <= r_presc + 24'd1;
            r_step_tick <= 1'b0;
        end
    end

    // X movement: left has priority over right, saturating at both edges
    always_comb begin
        w_joy_x_next = r_joy_x;
        if (r_step_tick) begin
            if (w_left) begin
                if (r_joy_x != 10'd0) begin
                    w_joy_x_next = r_joy_x - 10'd1;
                end
            end else if (w_right && (r_joy_x != X_MAX)) begin
                w_joy_x_next = r_joy_x + 10'd1;
            end
        end
    end

    // Y movement: up has priority over down, saturating at both edges
    always_comb begin
        w_joy_y_next = r_joy_y;
        if (r_step_tick) begin
            if (w_up) begin
                if (r_joy_y != 10'd0) begin
                    w_joy_y_next = r_joy_y - 10'd1;
                end
            end else if (w_down && (r_joy_y != Y_MAX)) begin
                w_joy_y_next = r_joy_y + 10'd1;
            end
        end
    end

    // Live joystick position register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_joy_x <= X_RESET;
            r_joy_y <= Y_RESET;
        end else begin
            r_joy_x <= w_joy_x_next;
            r_joy_y <= w_joy_y_next;
        end
    end

    // Frame latch: player takes the pre-step joystick value on the vsync rising edge
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_vsync_prev <= 1'b0;
            r_player_x   <= X_RESET;
            r_player_y   <= Y_RESET;
        end else begin
            r_vsync_prev <= i_vsync;
            if (w_vsync_rise) begin
                r_player_x <= r_joy_x;
                r_player_y <= r_joy_y;
            end
        end
    end

    // Beam compare strobes for the renderer
    always_comb begin
        o_hstart = (i_hpos == r_player_x);
        o_vstart = (i_vpos == r_player_y);
    end

    assign o_joy_x     = r_joy_x;
    assign o_joy_y     = r_joy_y;
    assign o_player_x  = r_player_x;
    assign o_player_y  = r_player_y;
    assign o_step_tick = r_step_tick;

endmodule

// File: tb/tb_sprite_position_ctrl.sv
// Self-checking bench for sprite_position_ctrl with TICK_DIV=4.
module tb_sprite_position_ctrl;

    localparam int TD    = 4;
    localparam int XMAX  = 624;
    localparam int YMAX  = 464;

    logic       clk;
    logic       reset;
    logic       left, right, up, down, vsync;
    logic [9:0] hpos, vpos;
    logic [9:0] joy_x, joy_y, player_x, player_y;
    logic       hstart, vstart, step_tick;

    int n_checks;
    int n_errors;

    // Reference model state
    int       m_jx, m_jy, m_px, m_py;
    int       m_edges;
    bit       m_vs_prev;
    bit [3:0] m_hist0, m_hist1;

    sprite_position_ctrl #(
        .H_DISPLAY(640),
        .V_DISPLAY(480),
        .SPRITE_W (16),
        .SPRITE_H (16),
        .TICK_DIV (TD)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_left     (left),
        .i_right    (right),
        .i_up       (up),
        .i_down     (down),
        .i_vsync    (vsync),
        .i_hpos     (hpos),
        .i_vpos     (vpos),
        .o_joy_x    (joy_x),
        .o_joy_y    (joy_y),
        .o_player_x (player_x),
        .o_player_y (player_y),
        .o_hstart   (hstart),
        .o_vstart   (vstart),
        .o_step_tick(step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_step();
        return (m_edges > 0) && (m_edges % TD == 0);
    endfunction

    function automatic logic [40:0] exp_vec();
        return {10'(m_jx), 10'(m_jy), 10'(m_px), 10'(m_py), exp_step()};
    endfunction

    function automatic logic [40:0] dut_vec();
        return {joy_x, joy_y, player_x, player_y, step_tick};
    endfunction

    task automatic model_reset();
        m_jx = 320; m_jy = 240; m_px = 320; m_py = 240;
        m_edges = 0; m_vs_prev = 0; m_hist0 = 0; m_hist1 = 0;
    endtask

    // Advance the model over one clock edge using the inputs present now, then clock the DUT.
    task automatic tick();
        bit [3:0] b_now;
        b_now = {left, right, up, down};
        if (vsync && !m_vs_prev) begin
            m_px = m_jx;
            m_py = m_jy;
        end
        if (exp_step()) begin
            if (m_hist1[3])      m_jx = (m_jx > 0) ? m_jx - 1 : 0;
            else if (m_hist1[2]) m_jx = (m_jx < XMAX) ? m_jx + 1 : XMAX;
            if (m_hist1[1])      m_jy = (m_jy > 0) ? m_jy - 1 : 0;
            else if (m_hist1[0]) m_jy = (m_jy < YMAX) ? m_jy + 1 : YMAX;
        end
        m_hist1   = m_hist0;
        m_hist0   = b_now;
        m_vs_prev = vsync;
        m_edges++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {left, right, up, down, vsync} = 5'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int last;
        reset = 1'b1;
        {left, right, up, down, vsync} = 5'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== {10'd320, 10'd240, 10'd320, 10'd240, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_state: got %h required %h", dut_vec(),
                     {10'd320, 10'd240, 10'd320, 10'd240, 1'b0});
        end
        do_reset();
        last = -1;
        for (int i = 0; i < 32; i++) begin
            vsync = (i % 10 == 5) || (i % 10 == 6);
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL idle_cycle%0d: got %h required %h", i, dut_vec(), exp_vec());
            end
            if (step_tick === 1'b1) begin
                if (last >= 0) begin
                    n_checks++;
                    if (i - last != TD) begin
                        n_errors++;
                        $display("FAIL step_period: got %0d required %0d", i - last, TD);
                    end
                end
                last = i;
            end
        end
        vsync = 1'b0;
        n_checks++;
        if ({joy_x, joy_y, player_x, player_y} !== {10'd320, 10'd240, 10'd320, 10'd240}) begin
            n_errors++;
            $display("FAIL idle_pos: got %0d,%0d,%0d,%0d required 320,240,320,240",
                     joy_x, joy_y, player_x, player_y);
        end
    endtask

    task automatic test_diagonal();
        do_reset();
        {left, right, down} = 3'b111;
        for (int i = 0; i < 41; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL diag_cycle%0d: got %h required %h", i, dut_vec(), exp_vec());
            end
        end
        {left, right, down} = 3'b000;
        n_checks++;
        if ({joy_x, joy_y} !== {10'd310, 10'd250}) begin
            n_errors++;
            $display("FAIL diag_joy: got %0d,%0d required 310,250", joy_x, joy_y);
        end
        vsync = 1'b1;
        #1;
        n_checks++;
        if ({player_x, player_y} !== {10'd320, 10'd240}) begin
            n_errors++;
            $display("FAIL diag_player_before: got %0d,%0d required 320,240",
                     player_x, player_y);
        end
        tick();
        n_checks++;
        if ({player_x, player_y} !== {10'd310, 10'd250}) begin
            n_errors++;
            $display("FAIL diag_player_after: got %0d,%0d required 310,250",
                     player_x, player_y);
        end
        for (int i = 0; i < 6; i++) tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic test_clamp();
        do_reset();
        right = 1'b1;
        for (int i = 0; i < 400 * TD + 4; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL clamp_right_cycle%0d: got %h required %h", i, dut_vec(),
                         exp_vec());
            end
        end
        n_checks++;
        if (joy_x !== 10'd624) begin
            n_errors++;
            $display("FAIL clamp_right: got %0d required 624", joy_x);
        end
        right = 1'b0;
        up    = 1'b1;
        for (int i = 0; i < 300 * TD + 4; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL clamp_up_cycle%0d: got %h required %h", i, dut_vec(), exp_vec());
            end
        end
        up = 1'b0;
        n_checks++;
        if (joy_y !== 10'd0) begin
            n_errors++;
            $display("FAIL clamp_up: got %0d required 0", joy_y);
        end
    endtask

    task automatic test_collision();
        int n;
        int budget;
        do_reset();
        right  = 1'b1;
        budget = 0;
        while (!(m_edges >= 12 && exp_step()) && budget < 100) begin
            tick();
            budget++;
        end
        n_checks++;
        if (step_tick !== 1'b1 || budget >= 100) begin
            n_errors++;
            $display("FAIL collide_align: step_tick got %b required 1", step_tick);
        end
        n     = m_jx;
        vsync = 1'b1;
        tick();
        n_checks++;
        if (player_x !== 10'(n) || joy_x !== 10'(n + 1)) begin
            n_errors++;
            $display("FAIL collide_order: got player_x=%0d joy_x=%0d required %0d,%0d",
                     player_x, joy_x, n, n + 1);
        end
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL collide_state: got %h required %h", dut_vec(), exp_vec());
        end
        right = 1'b0;
        vsync = 1'b0;
        tick();
    endtask

    task automatic test_strobes();
        do_reset();
        for (int h = 0; h < 800; h++) begin
            hpos = 10'(h);
            #1;
            n_checks++;
            if (hstart !== (h == 320)) begin
                n_errors++;
                $display("FAIL hstart_h%0d: got %b required %b", h, hstart, h == 320);
            end
        end
        for (int v = 0; v < 525; v++) begin
            vpos = 10'(v);
            #1;
            n_checks++;
            if (vstart !== (v == 240)) begin
                n_errors++;
                $display("FAIL vstart_v%0d: got %b required %b", v, vstart, v == 240);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        int budget;
        do_reset();
        right  = 1'b1;
        budget = 0;
        while (m_jx != 500 && budget < 2000) begin
            tick();
            budget++;
        end
        n_checks++;
        if (joy_x !== 10'd500) begin
            n_errors++;
            $display("FAIL areset_reach: got %0d required 500", joy_x);
        end
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (joy_x !== 10'd320 || step_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL areset_immediate: got joy_x=%0d step=%b required 320,0",
                     joy_x, step_tick);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec() !== {10'd320, 10'd240, 10'd320, 10'd240, 1'b0}) begin
            n_errors++;
            $display("FAIL areset_held: got %h required %h", dut_vec(),
                     {10'd320, 10'd240, 10'd320, 10'd240, 1'b0});
        end
        right = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 2 * TD; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL areset_restart%0d: got %h required %h", i, dut_vec(),
                         exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit ehs, evs;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) {left, right, up, down} = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) vsync = ~vsync;
            hpos = 10'(m_px + $urandom_range(0, 2) - 1);
            vpos = 10'(m_py + $urandom_range(0, 2) - 1);
            tick();
            ehs = (int'(hpos) == m_px);
            evs = (int'(vpos) == m_py);
            n_checks++;
            if ({dut_vec(), hstart, vstart} !== {exp_vec(), ehs, evs}) begin
                n_errors++;
                $display("FAIL random_cycle%0d: got %h required %h", i,
                         {dut_vec(), hstart, vstart}, {exp_vec(), ehs, evs});
            end
        end
        {left, right, up, down, vsync} = 5'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        hpos     = 10'd0;
        vpos     = 10'd0;
        test_reset();
        test_diagonal();
        test_clamp();
        test_collision();
        test_strobes();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
